// File: rtl/rtc_regacc_ctrl.sv
// RTC register access controller: arbitrates per-register read/write requests
// into single downstream I2C commands. Optional iDone timeout under RTC_TIMEOUT_EN.
module rtc_regacc_ctrl #(
    parameter int          NREG      = 7,
    parameter int          IDXW      = 3,
    parameter logic [7:0]  ADDR_BASE = 8'h02,
    parameter logic [15:0] TO_CYC    = 16'd50000
) (
    input  logic                CLOCK,
    input  logic                RST_n,
    input  logic [2*NREG-1:0]   iCall,
    input  logic [7:0]          iData,
    output logic                oDone,
    output logic                oErr,
    output logic [7:0]          oRdData,
    output logic [IDXW-1:0]     oIdx,
    output logic [1:0]          oCall,
    input  logic                iDone,
    input  logic [7:0]          iRdData,
    output logic [7:0]          oAddr,
    output logic [7:0]          oData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic            wr;
    logic            pick_any;
    logic            pick_wr;
    logic [IDXW-1:0] pick_idx;

    // Any write beats any read; scanning downward leaves the lowest set index.
    always_comb begin
        pick_any = |iCall;
        pick_wr  = |iCall[2*NREG-1:NREG];
        pick_idx = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if (pick_wr ? iCall[NREG+k] : iCall[k]) begin
                pick_idx = IDXW'(k);
            end
        end
    end

`ifdef RTC_TIMEOUT_EN
    logic [15:0] cnt;

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= IDLE;
            wr      <= 1'b0;
            oCall   <= 2'b00;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oRdData <= 8'h00;
            oIdx    <= '0;
            oAddr   <= 8'h00;
            oData   <= 8'h00;
            cnt     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    oErr  <= 1'b0;
                    cnt   <= 16'd0;
                    if (pick_any) begin
                        wr    <= pick_wr;
                        oIdx  <= pick_idx;
                        oAddr <= ADDR_BASE + 8'(pick_idx);
                        if (pick_wr) begin
                            oData <= iData;
                        end
                        oCall <= pick_wr ? 2'b10 : 2'b01;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iDone) begin
                        oCall <= 2'b00;
                        if (!wr) begin
                            oRdData <= iRdData;
                        end
                        oDone <= 1'b1;
                        state <= DONE;
                    end else if (cnt == TO_CYC - 16'd1) begin
                        oCall <= 2'b00;
                        oDone <= 1'b1;
                        oErr  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    oErr  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    // TO_CYC only matters with the timeout counter; folded into a constant zero here.
    assign oErr = 1'b0 & (|TO_CYC);

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= IDLE;
            wr      <= 1'b0;
            oCall   <= 2'b00;
            oDone   <= 1'b0;
            oRdData <= 8'h00;
            oIdx    <= '0;
            oAddr   <= 8'h00;
            oData   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (pick_any) begin
                        wr    <= pick_wr;
                        oIdx  <= pick_idx;
                        oAddr <= ADDR_BASE + 8'(pick_idx);
                        if (pick_wr) begin
                            oData <= iData;
                        end
                        oCall <= pick_wr ? 2'b10 : 2'b01;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iDone) begin
                        oCall <= 2'b00;
                        if (!wr) begin
                            oRdData <= iRdData;
                        end
                        oDone <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rtc_regacc_ctrl.sv
// Self-checking bench for rtc_regacc_ctrl: directed scenarios plus randomized
// back-to-back transactions against a behavioural pick/address model.
module tb_rtc_regacc_ctrl;
    localparam int         NREG = 7;
    localparam int         IDXW = 3;
    localparam logic [7:0] BASE = 8'h02;

    logic              CLOCK = 1'b0;
    logic              RST_n = 1'b0;
    logic [2*NREG-1:0] iCall = '0;
    logic [7:0]        iData = 8'h00;
    logic              iDone = 1'b0;
    logic [7:0]        iRdData = 8'h00;
    logic              oDone;
    logic              oErr;
    logic [7:0]        oRdData;
    logic [IDXW-1:0]   oIdx;
    logic [1:0]        oCall;
    logic [7:0]        oAddr;
    logic [7:0]        oData;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_rd = 8'h00;
    logic [7:0] exp_data = 8'h00;

    rtc_regacc_ctrl #(
        .NREG(NREG), .IDXW(IDXW), .ADDR_BASE(BASE), .TO_CYC(16'd16)
    ) dut (
        .CLOCK(CLOCK), .RST_n(RST_n), .iCall(iCall), .iData(iData),
        .oDone(oDone), .oErr(oErr), .oRdData(oRdData), .oIdx(oIdx),
        .oCall(oCall), .iDone(iDone), .iRdData(iRdData),
        .oAddr(oAddr), .oData(oData)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    // Reference rule: any write request wins; lowest index in the winning direction.
    function automatic void model_pick(input logic [2*NREG-1:0] c, output bit wr, output int idx);
        int wbits = int'(c) >> NREG;
        int rbits = int'(c) % (1 << NREG);
        int v;
        wr  = (wbits != 0);
        v   = wr ? wbits : rbits;
        idx = 0;
        while (v % 2 == 0 && idx < NREG) begin
            v = v / 2;
            idx++;
        end
    endfunction

    task automatic test_reset;
        RST_n = 1'b0;
        iCall = '0;
        iDone = 1'b0;
        tick();
        tick();
        checks++; if (oCall !== 2'b00)  begin failures++; $display("FAIL reset_oCall got=%b exp=00", oCall); end
        checks++; if (oDone !== 1'b0)   begin failures++; $display("FAIL reset_oDone got=%b exp=0", oDone); end
        checks++; if (oErr !== 1'b0)    begin failures++; $display("FAIL reset_oErr got=%b exp=0", oErr); end
        checks++; if (oRdData !== 8'h00) begin failures++; $display("FAIL reset_oRdData got=%h exp=00", oRdData); end
        checks++; if (oIdx !== 3'd0)    begin failures++; $display("FAIL reset_oIdx got=%0d exp=0", oIdx); end
        checks++; if (oAddr !== 8'h00)  begin failures++; $display("FAIL reset_oAddr got=%h exp=00", oAddr); end
        checks++; if (oData !== 8'h00)  begin failures++; $display("FAIL reset_oData got=%h exp=00", oData); end
        RST_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_write;
        iCall = 14'(1 << NREG);
        iData = 8'h24;
        tick();
        iCall = '0;
        checks++; if (oCall !== 2'b10) begin failures++; $display("FAIL write_oCall got=%b exp=10", oCall); end
        checks++; if (oAddr !== 8'h02) begin failures++; $display("FAIL write_oAddr got=%h exp=02", oAddr); end
        checks++; if (oData !== 8'h24) begin failures++; $display("FAIL write_oData got=%h exp=24", oData); end
        checks++; if (oIdx !== 3'd0)   begin failures++; $display("FAIL write_oIdx got=%0d exp=0", oIdx); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (oCall !== 2'b10 || oDone !== 1'b0) begin failures++; $display("FAIL write_hold got=%b/%b exp=10/0", oCall, oDone); end
        end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++; if (oDone !== 1'b1)  begin failures++; $display("FAIL write_oDone got=%b exp=1", oDone); end
        checks++; if (oCall !== 2'b00) begin failures++; $display("FAIL write_oCall_clear got=%b exp=00", oCall); end
        checks++; if (oErr !== 1'b0)   begin failures++; $display("FAIL write_oErr got=%b exp=0", oErr); end
        tick();
        checks++; if (oDone !== 1'b0)  begin failures++; $display("FAIL write_oDone_width got=%b exp=0", oDone); end
        exp_data = 8'h24;
        $display("test_write addr=%h data=%h done", oAddr, oData);
    endtask

    task automatic test_read;
        iCall = 14'(1 << 2);
        iData = 8'(($urandom % 255) + 1) ^ exp_data;
        tick();
        iCall = '0;
        checks++; if (oCall !== 2'b01)    begin failures++; $display("FAIL read_oCall got=%b exp=01", oCall); end
        checks++; if (oAddr !== 8'h04)    begin failures++; $display("FAIL read_oAddr got=%h exp=04", oAddr); end
        checks++; if (oIdx !== 3'd2)      begin failures++; $display("FAIL read_oIdx got=%0d exp=2", oIdx); end
        checks++; if (oData !== exp_data) begin failures++; $display("FAIL read_oData_kept got=%h exp=%h", oData, exp_data); end
        tick();
        tick();
        iRdData = 8'h57;
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        iRdData = 8'h00;
        checks++; if (oDone !== 1'b1)     begin failures++; $display("FAIL read_oDone got=%b exp=1", oDone); end
        checks++; if (oRdData !== 8'h57)  begin failures++; $display("FAIL read_oRdData got=%h exp=57", oRdData); end
        tick();
        checks++; if (oDone !== 1'b0 || oRdData !== 8'h57) begin failures++; $display("FAIL read_after got=%b/%h exp=0/57", oDone, oRdData); end
        exp_rd = 8'h57;
        $display("test_read rd=%h done", oRdData);
    endtask

    task automatic test_priority;
        iCall = 14'((1 << (NREG + 5)) | 1);
        iData = 8'hA5;
        tick();
        checks++; if (oCall !== 2'b10) begin failures++; $display("FAIL prio_oCall got=%b exp=10", oCall); end
        checks++; if (oAddr !== 8'h07) begin failures++; $display("FAIL prio_oAddr got=%h exp=07", oAddr); end
        checks++; if (oIdx !== 3'd5)   begin failures++; $display("FAIL prio_oIdx got=%0d exp=5", oIdx); end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        iCall = '0;
        exp_data = 8'hA5;
        tick();
        checks++; if (oCall !== 2'b00) begin failures++; $display("FAIL prio_idle got=%b exp=00", oCall); end
        iCall = 14'd1;
        tick();
        iCall = '0;
        checks++; if (oCall !== 2'b01 || oAddr !== 8'h02 || oIdx !== 3'd0) begin
            failures++; $display("FAIL prio_second got=%b/%h/%0d exp=01/02/0", oCall, oAddr, oIdx);
        end
        iRdData = 8'h3E;
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        exp_rd = 8'h3E;
        checks++; if (oRdData !== exp_rd) begin failures++; $display("FAIL prio_rd got=%h exp=%h", oRdData, exp_rd); end
        tick();
        $display("test_priority done");
    endtask

    task automatic test_hold_and_spurious;
        iCall = 14'(1 << (NREG + 3));
        iData = 8'h3C;
        tick();
        iData = 8'hFF;
        iCall = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (oData !== 8'h3C || oIdx !== 3'd3 || oCall !== 2'b10) begin
                failures++; $display("FAIL hold got=%h/%0d/%b exp=3C/3/10", oData, oIdx, oCall);
            end
        end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        iCall = '0;
        exp_data = 8'h3C;
        tick();
        iDone = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (oDone !== 1'b0 || oCall !== 2'b00) begin
                failures++; $display("FAIL spurious got=%b/%b exp=0/00", oDone, oCall);
            end
        end
        iDone = 1'b0;
        tick();
        $display("test_hold_and_spurious done");
    endtask

    task automatic test_back_to_back;
        logic [2*NREG-1:0] c;
        logic [7:0] d;
        logic [7:0] rd;
        bit wr;
        int idx;
        int dly;
        c = 14'($urandom_range(1, (1 << (2 * NREG)) - 1));
        iCall = c;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            rd = 8'($urandom);
            dly = $urandom_range(0, 4);
            iData = d;
            if (n > 0) begin
                tick();
                checks++; if (oDone !== 1'b0 || oCall !== 2'b00) begin
                    failures++; $display("FAIL b2b_idle n=%0d got=%b/%b exp=0/00", n, oDone, oCall);
                end
            end
            model_pick(c, wr, idx);
            if (wr) exp_data = d;
            tick();
            iCall = 14'($urandom);
            iData = 8'($urandom);
            checks++; if (oCall !== (wr ? 2'b10 : 2'b01) || oAddr !== 8'((int'(BASE) + idx) % 256) ||
                          oIdx !== IDXW'(idx) || oData !== exp_data) begin
                failures++;
                $display("FAIL b2b_issue n=%0d got=%b/%h/%0d/%h exp=%b/%h/%0d/%h", n, oCall, oAddr, oIdx, oData,
                         wr ? 2'b10 : 2'b01, 8'((int'(BASE) + idx) % 256), idx, exp_data);
            end
            for (int k = 0; k < dly; k++) begin
                tick();
                checks++; if (oCall !== (wr ? 2'b10 : 2'b01) || oDone !== 1'b0) begin
                    failures++; $display("FAIL b2b_hold n=%0d got=%b/%b", n, oCall, oDone);
                end
            end
            iRdData = rd;
            iDone = 1'b1;
            tick();
            iDone = 1'b0;
            if (!wr) exp_rd = rd;
            checks++; if (oDone !== 1'b1 || oCall !== 2'b00 || oRdData !== exp_rd || oErr !== 1'b0) begin
                failures++; $display("FAIL b2b_done n=%0d got=%b/%b/%h exp=1/00/%h", n, oDone, oCall, oRdData, exp_rd);
            end
            $display("b2b n=%0d call=%h wr=%0d idx=%0d addr=%h data=%h rd=%h", n, c, wr, idx, oAddr, oData, oRdData);
            c = (n == 39) ? '0 : 14'($urandom_range(1, (1 << (2 * NREG)) - 1));
            iCall = c;
        end
        tick();
        tick();
    endtask

    task automatic test_timeout;
        int n;
        int bad;
        iCall = 14'(1 << 1);
        tick();
        iCall = '0;
        checks++; if (oCall !== 2'b01) begin failures++; $display("FAIL to_start got=%b exp=01", oCall); end
`ifdef RTC_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (oDone === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++; if (n != 16) begin failures++; $display("FAIL to_latency got=%0d exp=16", n); end
        checks++; if (oErr !== 1'b1 || oCall !== 2'b00 || oRdData !== exp_rd) begin
            failures++; $display("FAIL to_outputs got=%b/%b/%h exp=1/00/%h", oErr, oCall, oRdData, exp_rd);
        end
        tick();
        checks++; if (oDone !== 1'b0 || oErr !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b/%b exp=0/0", oDone, oErr); end
        $display("test_timeout latency=%0d", n);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (oCall !== 2'b01 || oDone !== 1'b0 || oErr !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL no_timeout bad_cycles got=%0d exp=0", bad); end
        iRdData = 8'h9C;
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        exp_rd = 8'h9C;
        checks++; if (oDone !== 1'b1 || oErr !== 1'b0 || oRdData !== exp_rd) begin
            failures++; $display("FAIL no_timeout_done got=%b/%b/%h exp=1/0/%h", oDone, oErr, oRdData, exp_rd);
        end
        tick();
        $display("test_timeout held 1000 cycles");
`endif
    endtask

    task automatic test_reset_mid_issue;
        int bad;
        iCall = 14'(1 << (NREG + 6));
        iData = 8'h6B;
        tick();
        iCall = '0;
        checks++; if (oCall !== 2'b10 || oAddr !== 8'h08) begin failures++; $display("FAIL rst_mid_start got=%b/%h exp=10/08", oCall, oAddr); end
        tick();
        #3;
        RST_n = 1'b0;
        #1;
        checks++; if (oCall !== 2'b00 || oDone !== 1'b0 || oErr !== 1'b0 || oRdData !== 8'h00 ||
                      oIdx !== 3'd0 || oAddr !== 8'h00 || oData !== 8'h00) begin
            failures++; $display("FAIL rst_mid_async got=%b/%b/%b/%h/%0d/%h/%h exp=all zero",
                                 oCall, oDone, oErr, oRdData, oIdx, oAddr, oData);
        end
        tick();
        RST_n = 1'b1;
        iDone = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            iDone = 1'b0;
            if (oDone !== 1'b0 || oCall !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", bad); end
        $display("test_reset_mid_issue done");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_hold_and_spurious();
        test_back_to_back();
        test_timeout();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rtc_regacc_ctrl.md
RTC_REGACC_CTRL -- requirements
Module: rtc_regacc_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 7, number of contiguous RTC registers served (1..2**IDXW).
REQ-002 SHALL have parameter IDXW, default 3, width of the register index.
REQ-003 SHALL have parameter ADDR_BASE, default 8'h02, device sub-address of register index 0.
REQ-004 SHALL have parameter TO_CYC, default 16'd50000, iDone timeout in CLOCK cycles, used only under RTC_TIMEOUT_EN.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: CLOCK  in  1  clock; RST_n  in  1  async active-low reset.
REQ-006 SHALL have iCall  in  2*NREG  request vector: bit NREG+k writes register k; bit k reads register k.
REQ-007 SHALL have iData  in  8  write data, sampled at request acceptance.
REQ-008 SHALL have oDone  out  1  one-cycle completion pulse to caller.
REQ-009 SHALL have oErr  out  1  one-cycle timeout pulse, coincident with oDone.
REQ-010 SHALL have oRdData  out  8  last read byte, held until the next read completes.
REQ-011 SHALL have oIdx  out  IDXW  index of the current or last transaction.
REQ-012 SHALL have oCall  out  2  downstream I2C command: 2'b10 write, 2'b01 read, 2'b00 idle.
REQ-013 SHALL have iDone  in  1  downstream completion pulse.
REQ-014 SHALL have iRdData  in  8  downstream read byte, valid with iDone.
REQ-015 SHALL have oAddr  out  8  sub-address to downstream; oData  out  8  write byte to downstream.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DONE.
REQ-017 IDLE: on any nonzero iCall, SHALL latch direction, index, oAddr = ADDR_BASE + index (mod 256), and oData = iData (write only), then go to ISSUE on the next edge.
REQ-018 Arbitration for multiple set bits SHALL give any write priority over any read, and the lowest index first within each direction.
REQ-019 ISSUE: oCall SHALL be asserted from the first ISSUE cycle and held constant until iDone.
REQ-020 ISSUE on iDone: SHALL clear oCall to 2'b00 and go to DONE; on a read, SHALL capture iRdData into oRdData.
REQ-021 DONE: oDone SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-022 Request-to-oCall latency SHALL be 1 cycle; iDone-to-oDone latency SHALL be 1 cycle.
REQ-023 Changes to iCall or iData during ISSUE or DONE SHALL be ignored; latched values SHALL remain stable.
REQ-024 The caller deasserts iCall on the oDone cycle; an iCall still nonzero in the following IDLE cycle SHALL start a new transaction.
REQ-025 Bits of iCall mapping to an index >= NREG do not exist; oAddr SHALL never exceed ADDR_BASE+NREG-1.
REQ-026 iDone asserted while in IDLE or DONE SHALL be ignored.

Reset
REQ-027 RST_n low SHALL asynchronously force state IDLE, oCall=2'b00, oDone=0, oErr=0, oRdData=8'h00, oIdx=0, oAddr=8'h00, oData=8'h00, and clear the timeout counter.
REQ-028 Reset asserted mid-ISSUE SHALL drop oCall the same instant; no oDone SHALL be produced for the aborted transaction.

Configuration
REQ-029 With macro RTC_TIMEOUT_EN defined, a counter SHALL run in ISSUE; if it reaches TO_CYC-1 without iDone, the block SHALL clear oCall, leave oRdData unchanged, go to DONE, and pulse oErr with oDone.
REQ-030 With RTC_TIMEOUT_EN undefined, ISSUE SHALL wait indefinitely, oErr SHALL be tied 0, and no counter SHALL be synthesised.

Verification
REQ-031 Reset, then iCall bit NREG+0 with iData=8'h24 -> next cycle oCall=2'b10, oAddr=8'h02, oData=8'h24; iDone after 5 cycles -> oDone pulse 1 cycle later, oCall=2'b00.
REQ-032 Read bit 2 with iRdData=8'h57 at iDone -> oCall=2'b01, oAddr=8'h04, oRdData=8'h57, oIdx=2, oDone 1 cycle.
REQ-033 Write bit 5 and read bit 0 applied together -> write of index 5 (oAddr=8'h07) served first; read index 0 served after iCall is re-presented.
REQ-034 iData changed to 8'hFF during ISSUE -> oData holds its accepted value; spurious iDone in IDLE -> no oDone.
REQ-035 RTC_TIMEOUT_EN, TO_CYC=16, no iDone -> oCall drops, oDone and oErr pulse together 16 cycles after oCall rises; without the macro, oCall holds for 1000 cycles.
REQ-036 RST_n pulled low mid-ISSUE -> all outputs at reset values immediately; no oDone after release.
